// File: rtl/lut_neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lut_neuron_pkg
// Brief   : Shared constants and FSM state encoding for the LUT neuron.
// Revision: 1.0
// ============================================================================
package lut_neuron_pkg;

    localparam int C_IN_BITS  = 6;
    localparam int C_OUT_BITS = 2;
    localparam int C_DEPTH    = 2 ** C_IN_BITS;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/lut_neuron_ram.sv
`default_nettype none
// ============================================================================
// Module  : lut_neuron_ram
// Brief   : Distributed truth-table RAM, one write port, one async read port.
// Revision: 1.0
// ============================================================================
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int ADDR_BITS = C_IN_BITS,
    parameter int DATA_BITS = C_OUT_BITS,
    parameter int DEPTH     = C_DEPTH
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    // Contents are deliberately not reset: a reload is the only way to refill.
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/lut_neuron_prog.sv
`default_nettype none
// ============================================================================
// Module  : lut_neuron_prog
// Brief   : Programmable LUT neuron: streamed table load, then 1-cycle lookups.
//           Optional per-entry even parity when LUT_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
module lut_neuron_prog
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = C_IN_BITS,
    parameter int OUT_BITS = C_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                loaded,
    output logic                cfg_err
`ifdef LUT_PARITY_EN
    ,
    output logic                par_err
`endif
);

`ifdef LUT_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int RAM_BITS = OUT_BITS + PAR_BITS;
    localparam logic [IN_BITS-1:0] C_ADDR_LAST = '1;
    localparam logic [IN_BITS-1:0] C_ADDR_ONE  = {{(IN_BITS-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [IN_BITS-1:0]    wr_addr_q, wr_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0]   out_data_q, out_data_d;
    logic                  loaded_q, loaded_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  cfg_hs;
    logic                  in_hs;
    logic [IN_BITS-1:0]    cfg_addr;
    logic [RAM_BITS-1:0]   ram_wdata;
    logic [RAM_BITS-1:0]   ram_rdata;
    logic [OUT_BITS-1:0]   lookup_data;
    logic                  parity_bad;

`ifdef LUT_PARITY_EN
    logic                  par_err_q, par_err_d;
    assign ram_wdata = {^cfg_data, cfg_data};
    always_comb begin
        parity_bad  = ^ram_rdata;
        lookup_data = parity_bad ? '0 : ram_rdata[OUT_BITS-1:0];
    end
    assign par_err = par_err_q;
`else
    assign ram_wdata   = cfg_data;
    assign parity_bad  = 1'b0;
    assign lookup_data = ram_rdata;
`endif

    // A load always starts at address 0, whether entered from EMPTY or RUN.
    assign cfg_addr = (state_q == LOAD) ? wr_addr_q : '0;
    assign cfg_hs   = cfg_valid && cfg_ready;
    assign in_hs    = in_valid && in_ready;

    lut_neuron_ram #(
        .ADDR_BITS (IN_BITS),
        .DATA_BITS (RAM_BITS),
        .DEPTH     (2 ** IN_BITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (cfg_hs && rst_n),
        .waddr_i (cfg_addr),
        .wdata_i (ram_wdata),
        .raddr_i (in_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        cfg_ready   = 1'b0;
        in_ready    = 1'b0;
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        loaded_d    = loaded_q;
        cfg_err_d   = cfg_err_q;
`ifdef LUT_PARITY_EN
        par_err_d   = par_err_q;
`endif

        case (state_q)
            EMPTY, LOAD: cfg_ready = 1'b1;
            RUN: begin
                // A pending reload blocks new lookups and waits for the output to drain.
                cfg_ready = !out_valid_q;
                in_ready  = !cfg_valid && (!out_valid_q || out_ready);
            end
            default: cfg_ready = 1'b0;
        endcase

        if (in_hs) begin
            out_valid_d = 1'b1;
            out_data_d  = lookup_data;
`ifdef LUT_PARITY_EN
            if (parity_bad) begin
                par_err_d = 1'b1;
            end
`endif
        end

        if (cfg_hs) begin
            loaded_d  = 1'b0;
            cfg_err_d = 1'b0;
            wr_addr_d = '0;
`ifdef LUT_PARITY_EN
            par_err_d = 1'b0;
`endif
            if (cfg_last && (cfg_addr == C_ADDR_LAST)) begin
                state_d  = RUN;
                loaded_d = 1'b1;
            end else if (cfg_last || (cfg_addr == C_ADDR_LAST)) begin
                state_d   = EMPTY;
                cfg_err_d = 1'b1;
            end else begin
                state_d   = LOAD;
                wr_addr_d = cfg_addr + C_ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            wr_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            loaded_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef LUT_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            loaded_q    <= loaded_d;
            cfg_err_q   <= cfg_err_d;
`ifdef LUT_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign loaded    = loaded_q;
    assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_prog.sv
`default_nettype none
// ============================================================================
// Module  : tb_lut_neuron_prog
// Brief   : Self-checking bench for lut_neuron_prog with a lookup scoreboard.
// Revision: 1.0
// ============================================================================
module tb_lut_neuron_prog;

    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 2;
    localparam int DEPTH    = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_last;
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;
    logic                loaded;
    logic                cfg_err;
`ifdef LUT_PARITY_EN
    logic                par_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [OUT_BITS-1:0] model [DEPTH];
    logic [OUT_BITS-1:0] sb_q [$];

    lut_neuron_prog #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .loaded    (loaded),
        .cfg_err   (cfg_err)
`ifdef LUT_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] entry_a(input int i);
        if (i == 36) return 2'b01;
        return ((i >> 3) & 1) != 0 ? 2'b11 : 2'b10;
    endfunction

    function automatic logic [1:0] entry_b(input int i);
        logic [1:0] v;
        v = i[1:0];
        return v ^ 2'b11;
    endfunction

    // Negedge sample point: scoreboard pops on output handshakes, pushes on lookups.
    task automatic half();
        logic [1:0] exp;
        @(negedge clk);
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: out_data=%b with no lookup pending", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL sb_data: out_data=%b required %b", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model[in_data]);
        end
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        rise();
        rise();
        rst_n = 1'b1;
    endtask

    task automatic cfg_send(input logic [1:0] d, input logic last, input int addr);
        int n;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        n = 0;
        half();
        while (!cfg_ready && n < 50) begin
            rise();
            half();
            n++;
        end
        checks++;
        if (!cfg_ready) begin
            errors++;
            $display("FAIL cfg_wait: cfg_ready=%b required 1 at entry %0d", cfg_ready, addr);
        end
        model[addr] = d;
        rise();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic load_range(input bit use_b, input int first, input int last_at, input int count);
        for (int i = first; i < count; i++) begin
            cfg_send(use_b ? entry_b(i) : entry_a(i), i == last_at, i);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        half();
        while (sb_q.size() != 0 && n < 20) begin
            rise();
            half();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", sb_q.size());
        end
        rise();
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1'b1;
        in_data  = '0;
        half();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL rst_out_data: got %b want 00", out_data); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded: got %b want 0", loaded); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
        rise();
        half();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_ignore_in: out_valid=%b want 0", out_valid); end
        rise();
        in_valid = 1'b0;
    endtask

    task automatic test_load_lookup();
        load_range(1'b0, 0, 63, 64);
        half();
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL load_loaded: got %b want 1", loaded); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_cfg_err: got %b want 0", cfg_err); end
        rise();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 6'b100100;
        half();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid=%b want 0", out_valid); end
        rise();
        in_valid = 1'b0;
        half();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_one: out_valid=%b want 1", out_valid); end
        checks++; if (out_data !== 2'b01) begin errors++; $display("FAIL lookup_36: got %b want 01", out_data); end
        rise();
        half();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_result: out_valid=%b want 0", out_valid); end
        rise();
    endtask

    task automatic test_back_to_back();
        logic [5:0] addrs [3];
        addrs = '{6'h00, 6'h08, 6'h24};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = addrs[k];
            half();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b want 1", k, in_ready); end
            if (k > 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b want 1", k, out_valid); end
            end
            rise();
        end
        in_valid = 1'b0;
        half();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_last: got %b want 1", out_valid); end
        checks++; if (out_data !== 2'b01) begin errors++; $display("FAIL b2b_last_data: got %b want 01", out_data); end
        rise();
        half();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d want 0", sb_q.size()); end
        rise();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'h08;
        half();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept: in_ready=%b want 1", in_ready); end
        rise();
        in_data = 6'h24;
        for (int c = 0; c < 3; c++) begin
            half();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", c, out_valid); end
            checks++; if (out_data !== 2'b11) begin errors++; $display("FAIL stall_data%0d: got %b want 11", c, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %b want 0", c, in_ready); end
            rise();
        end
        out_ready = 1'b1;
        half();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: in_ready=%b want 1", in_ready); end
        rise();
        in_valid = 1'b0;
        half();
        checks++; if (out_data !== 2'b01) begin errors++; $display("FAIL stall_second: got %b want 01", out_data); end
        rise();
        drain();
    endtask

    task automatic test_reload();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'h00;
        half();
        rise();
        in_valid  = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = entry_b(0);
        cfg_last  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            half();
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reload_wait%0d: cfg_ready=%b want 0", c, cfg_ready); end
            checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL reload_loaded%0d: got %b want 1", c, loaded); end
            rise();
        end
        out_ready = 1'b1;
        half();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reload_drain: cfg_ready=%b want 0", cfg_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reload_in_ready: got %b want 0", in_ready); end
        rise();
        cfg_send(entry_b(0), 1'b0, 0);
        half();
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reload_clear: loaded=%b want 0", loaded); end
        rise();
        load_range(1'b1, 1, 63, 64);
        half();
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL reload_done: loaded=%b want 1", loaded); end
        rise();
        in_valid = 1'b1;
        in_data  = 6'h24;
        half();
        rise();
        in_valid = 1'b0;
        half();
        checks++; if (out_data !== 2'b11) begin errors++; $display("FAIL reload_lookup: got %b want 11", out_data); end
        rise();
        drain();
    endtask

    task automatic test_cfg_errors();
        load_range(1'b0, 0, 10, 11);
        in_valid = 1'b1;
        in_data  = 6'h24;
        half();
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL early_err: got %b want 1", cfg_err); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL early_loaded: got %b want 0", loaded); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL early_in_ready: got %b want 0", in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL early_empty: cfg_ready=%b want 1", cfg_ready); end
        rise();
        in_valid = 1'b0;
        load_range(1'b0, 0, -1, 64);
        half();
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL nolast_err: got %b want 1", cfg_err); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL nolast_loaded: got %b want 0", loaded); end
        rise();
        cfg_send(entry_a(0), 1'b0, 0);
        half();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", cfg_err); end
        rise();
        load_range(1'b0, 1, 63, 64);
        half();
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL err_reload: loaded=%b want 1", loaded); end
        rise();
        in_valid = 1'b1;
        in_data  = 6'h24;
        half();
        rise();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_load();
        load_range(1'b1, 0, -1, 30);
        cfg_valid = 1'b1;
        cfg_data  = entry_b(30);
        rst_n     = 1'b0;
        sb_q.delete();
        rise();
        cfg_valid = 1'b0;
        rst_n     = 1'b1;
        half();
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL mid_loaded: got %b want 0", loaded); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL mid_cfg_err: got %b want 0", cfg_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL mid_out_data: got %b want 00", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        rise();
        load_range(1'b0, 0, 63, 64);
        half();
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL mid_reload: loaded=%b want 1", loaded); end
        rise();
        in_valid = 1'b1;
        in_data  = 6'h24;
        half();
        rise();
        in_data = 6'h3F;
        half();
        rise();
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_load_lookup();
        test_back_to_back();
        test_stall();
        test_reload();
        test_cfg_errors();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
